// File: rtl/vc_plane_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : vc_plane_scheduler
// Description : Round-robin time-multiplexing of one router switch across VC
//               planes, draining wormhole packets before each hand-off.
// Revision    : 1.0 - initial release
// ============================================================================
module vc_plane_scheduler #(
    parameter int VC      = 4,
    parameter int INPUTS  = 4,
    parameter int QUANTUM = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [VC-1:0][INPUTS-1:0]     valid_out_portVC,
    input  logic [VC-1:0][INPUTS-1:0]     PortReservedVC,
    output logic [VC:0]                   VCPlaneSelector,
    output logic                          plane_active,
    output logic [VC-1:0]                 allocBlock,
    output logic                          plane_switch
);

    localparam int SELW = VC + 1;
    localparam int IW   = (VC > 1) ? $clog2(VC) : 1;
    localparam int CW   = $clog2(QUANTUM);
    localparam logic [CW-1:0] c_CNT_LAST = CW'(QUANTUM - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    state_t            r_state;
    logic [CW-1:0]     r_cnt;
    logic [SELW-1:0]   r_sel;
    logic              r_active;
    logic [VC-1:0]     r_allocBlock;
    logic              r_switch;

    logic [VC-1:0]     w_req;
    logic [VC-1:0]     w_selOneHot;
    logic [SELW-1:0]   w_pick;
    logic              w_other;
    logic              w_reqSel;
    logic              w_reservedSel;

    for (genvar v = 0; v < VC; v++) begin : g_req
        assign w_req[v] = (|valid_out_portVC[v]) | (|PortReservedVC[v]);
    end

    // Search starts just after the current owner so the owner is considered last.
    function automatic logic [SELW-1:0] pickNext(input logic [SELW-1:0] cur,
                                                 input logic [VC-1:0]   req);
        logic [SELW-1:0] res;
        logic            found;
        int              idx;
        res   = cur;
        found = 1'b0;
        for (int i = 1; i <= VC; i++) begin
            idx = (int'(cur) + i) % VC;
            if (!found && req[idx[IW-1:0]]) begin
                res   = SELW'(idx);
                found = 1'b1;
            end
        end
        return res;
    endfunction

    assign w_pick        = pickNext(r_sel, w_req);
    assign w_selOneHot   = VC'(1) << r_sel;
    assign w_other       = |(w_req & ~w_selOneHot);
    assign w_reqSel      = w_req[r_sel[IW-1:0]];
    assign w_reservedSel = |PortReservedVC[r_sel[IW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_sel        <= '0;
            r_active     <= 1'b0;
            r_allocBlock <= '0;
            r_switch     <= 1'b0;
        end else begin
            r_switch <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (|w_req) begin
                        r_state  <= ACTIVE;
                        r_sel    <= w_pick;
                        r_cnt    <= '0;
                        r_active <= 1'b1;
                        r_switch <= 1'b1;
                    end
                end
                ACTIVE: begin
                    // An emptied owner yields immediately, ahead of quantum expiry.
                    if (!w_reqSel) begin
                        r_cnt <= '0;
                        if (w_other) begin
                            r_sel    <= w_pick;
                            r_switch <= 1'b1;
                        end else begin
                            r_state  <= IDLE;
                            r_active <= 1'b0;
                        end
                    end else if (r_cnt == c_CNT_LAST) begin
                        if (w_other) begin
                            r_state      <= DRAIN;
                            r_allocBlock <= w_selOneHot;
                        end else begin
                            r_cnt <= '0;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                DRAIN: begin
                    if (!w_reservedSel) begin
                        r_state      <= ACTIVE;
                        r_allocBlock <= '0;
                        r_cnt        <= '0;
                        if (w_other) begin
                            r_sel    <= w_pick;
                            r_switch <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state      <= IDLE;
                    r_active     <= 1'b0;
                    r_allocBlock <= '0;
                end
            endcase
        end
    end

    assign VCPlaneSelector = r_sel;
    assign plane_active    = r_active;
    assign allocBlock      = r_allocBlock;
    assign plane_switch    = r_switch;

endmodule
`default_nettype wire
